puf_response_ctrl: RTL and testbench
====================================

PUF_RESPONSE_CTRL -- requirements
Module: puf_response_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of each ring-oscillator edge count.
REQ-002 Parameter WINDOW, default 1000, measurement window in clk cycles; legal range 1..65535.
REQ-003 Parameter RESP_BITS, default 8, number of RO pairs compared and response bits produced; legal range 1..8.
REQ-004 Port clk  in  1  single system clock; all logic on rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port start  in  1  one-cycle request to generate a response; sampled only in IDLE.
REQ-007 Port challenge  in  RESP_BITS  per-pair swap mask, captured on accepted start.
REQ-008 Port count_a  in  CNT_W  edge count from the counter on RO index sel_a.
REQ-009 Port count_b  in  CNT_W  edge count from the counter on RO index sel_b.
REQ-010 Port ctr_clear  out  1  active-high clear to both frequency counters; integrator inverts it to drive counter reset_n.
REQ-011 Port ctr_enable  out  1  count enable to both frequency counters.
REQ-012 Port sel_a  out  4  RO index routed to counter A.
REQ-013 Port sel_b  out  4  RO index routed to counter B.
REQ-014 Port busy  out  1  high in every state except IDLE.
REQ-015 Port done  out  1  one-cycle pulse when the full response is complete.
REQ-016 Port response  out  RESP_BITS  response word; bit i belongs to pair i.
REQ-017 Port response_valid  out  1  high from done until the next accepted start or reset.
REQ-018 Port tie  out  1  sticky: some pair in the current run had count_a == count_b.
REQ-019 Port overflow  out  1  sticky: some pair in the current run had a count at all-ones (possible wrap).

Function
REQ-020 FSM states: IDLE, CLEAR, MEASURE, SETTLE, COMPARE, DONE.
REQ-021 IDLE -> CLEAR on start=1, which also captures challenge, sets pair index i=0, and clears response, response_valid, tie and overflow.
REQ-022 CLEAR: lasts 1 cycle, ctr_clear=1, ctr_enable=0, then -> MEASURE.
REQ-023 MEASURE: ctr_enable=1 for exactly WINDOW cycles, timed by an internal window counter, then -> SETTLE.
REQ-024 SETTLE: lasts 2 cycles with ctr_enable=0 so the counters' edge-detect registers flush, then -> COMPARE.
REQ-025 COMPARE: lasts 1 cycle, with bit = (count_a > count_b) XOR challenge[i], and response[i] <= bit.
REQ-026 Tie in COMPARE (count_a == count_b): response[i] <= challenge[i] and tie <= 1.
REQ-027 Overflow in COMPARE: overflow <= 1 if count_a or count_b equals all-ones.
REQ-028 From COMPARE: if i == RESP_BITS-1 -> DONE; else i <= i+1 and -> CLEAR.
REQ-029 DONE: lasts 1 cycle, done=1, response_valid <= 1, then -> IDLE.
REQ-030 Pair mapping: sel_a = 2*i and sel_b = 2*i+1; both are stable from CLEAR through COMPARE of pair i.
REQ-031 Per-pair latency is WINDOW+4 cycles; total from the accepted start to the done pulse is RESP_BITS*(WINDOW+4)+1 cycles.
REQ-032 start while busy is ignored, with no effect on state, i, or captured challenge.
REQ-033 ctr_clear and ctr_enable are never high in the same cycle, and both are 0 in IDLE and DONE.
REQ-034 Response bits not yet compared in the current run read 0.
REQ-035 Count comparison is unsigned and full CNT_W width, with no truncation.

Reset
REQ-036 When reset=1 at a clock edge, next state is IDLE, i=0, and the window counter is 0.
REQ-037 Reset values: busy=0, done=0, response=0, response_valid=0, tie=0, overflow=0, ctr_enable=0, sel_a=0, sel_b=0.
REQ-038 Reset value of ctr_clear is 1 (counters are held clear while reset is asserted); it goes to 0 in IDLE.
REQ-039 Reset mid-run abandons the run; no done pulse is produced, and the first start after reset begins a fresh run.

Verification
REQ-040 Basic run: WINDOW=4, RESP_BITS=2, challenge=2'b00, pair0 counts A=10/B=7, pair1 A=3/B=9 -> response=2'b01, done exactly 17 cycles after start, tie=0.
REQ-041 Challenge swap: same counts with challenge=2'b11 -> response=2'b10.
REQ-042 Tie: pair0 counts A=5/B=5, challenge bit 1 -> response[0]=1 and tie=1 at done.
REQ-043 Overflow: count_a=16'hFFFF in a COMPARE cycle -> overflow=1 at done; a later start clears it.
REQ-044 Ignored start: pulse start during MEASURE -> no restart, and done still occurs at the original cycle.
REQ-045 Mid-run reset: assert reset during the second MEASURE -> busy=0, response=0, no done; a following start completes normally.

Source files
------------

// File: rtl/puf_response_ctrl.sv
`timescale 1ns/1ps
// puf_response_ctrl: sequences ring-oscillator pair measurements for a PUF.
// For each pair i it clears the two edge counters, enables them for WINDOW
// cycles, lets them settle, then compares the counts to form response bit i.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   start            one-cycle request, sampled only in IDLE
//   challenge        per-pair swap mask, captured on accepted start
//   count_a/count_b  edge counts from counters on sel_a / sel_b
//   ctr_clear        active-high clear to both counters
//   ctr_enable       count enable to both counters
//   sel_a/sel_b      RO indices (2*i, 2*i+1) routed to counters A/B
//   busy             high in every state except IDLE
//   done             one-cycle pulse when the response is complete
//   response         response word, bit i from pair i
//   response_valid   high from done until next accepted start or reset
//   tie/overflow     sticky per-run flags (equal counts / all-ones count)
module puf_response_ctrl #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned WINDOW    = 1000,
    parameter int unsigned RESP_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [RESP_BITS-1:0] challenge,
    input  logic [CNT_W-1:0]     count_a,
    input  logic [CNT_W-1:0]     count_b,
    output logic                 ctr_clear,
    output logic                 ctr_enable,
    output logic [3:0]           sel_a,
    output logic [3:0]           sel_b,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] response,
    output logic                 response_valid,
    output logic                 tie,
    output logic                 overflow
);

    localparam int unsigned IDX_W = 3;
    localparam int unsigned WIN_W = 16;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RESP_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_MEASURE = 3'd2,
        S_SETTLE  = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [WIN_W-1:0]     r_win;
    logic [RESP_BITS-1:0] r_chal;

    logic                 w_chal_bit;
    logic [RESP_BITS-1:0] w_bit_mask;
    logic                 w_gt;
    logic                 w_eq;
    logic                 w_ovf;
    logic                 w_bit;
    logic [IDX_W-1:0]     w_next_idx;

    // Decode the current pair index into a challenge bit and a one-hot mask
    always_comb begin
        w_chal_bit = 1'b0;
        w_bit_mask = '0;
        for (int k = 0; k < int'(RESP_BITS); k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_chal_bit    = r_chal[k];
                w_bit_mask[k] = 1'b1;
            end
        end
    end

    // Full-width unsigned compare; on a tie w_gt=0 so the bit equals the challenge bit
    assign w_gt       = (count_a > count_b);
    assign w_eq       = (count_a == count_b);
    assign w_ovf      = (count_a == CNT_ONES) || (count_b == CNT_ONES);
    assign w_bit      = w_gt ^ w_chal_bit;
    assign w_next_idx = r_idx + IDX_W'(1);

    // Sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_win          <= '0;
            r_chal         <= '0;
            ctr_clear      <= 1'b1;
            ctr_enable     <= 1'b0;
            sel_a          <= 4'd0;
            sel_b          <= 4'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            response       <= '0;
            response_valid <= 1'b0;
            tie            <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    ctr_clear  <= 1'b0;
                    ctr_enable <= 1'b0;
                    if (start) begin
                        r_chal         <= challenge;
                        r_idx          <= '0;
                        sel_a          <= 4'd0;
                        sel_b          <= 4'd1;
                        response       <= '0;
                        response_valid <= 1'b0;
                        tie            <= 1'b0;
                        overflow       <= 1'b0;
                        busy           <= 1'b1;
                        ctr_clear      <= 1'b1;
                        r_state        <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    ctr_clear  <= 1'b0;
                    ctr_enable <= 1'b1;
                    r_win      <= '0;
                    r_state    <= S_MEASURE;
                end
                S_MEASURE: begin
                    if (r_win == WIN_LAST) begin
                        ctr_enable <= 1'b0;
                        r_win      <= '0;
                        r_state    <= S_SETTLE;
                    end else begin
                        r_win <= r_win + WIN_W'(1);
                    end
                end
                // Two idle cycles so the counters' edge-detect pipelines drain
                S_SETTLE: begin
                    if (r_win == WIN_W'(1)) begin
                        r_win   <= '0;
                        r_state <= S_COMPARE;
                    end else begin
                        r_win <= r_win + WIN_W'(1);
                    end
                end
                S_COMPARE: begin
                    response <= (response & ~w_bit_mask) | (w_bit ? w_bit_mask : '0);
                    if (w_eq) begin
                        tie <= 1'b1;
                    end
                    if (w_ovf) begin
                        overflow <= 1'b1;
                    end
                    if (r_idx == IDX_LAST) begin
                        done           <= 1'b1;
                        response_valid <= 1'b1;
                        r_state        <= S_DONE;
                    end else begin
                        r_idx     <= w_next_idx;
                        sel_a     <= {w_next_idx, 1'b0};
                        sel_b     <= {w_next_idx, 1'b1};
                        ctr_clear <= 1'b1;
                        r_state   <= S_CLEAR;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_response_ctrl.sv
`timescale 1ns/1ps
// Directed bench for puf_response_ctrl with WINDOW=4, RESP_BITS=2.
// Counter outputs are modelled as fixed per-pair counts selected by sel_a/sel_b.
module tb_puf_response_ctrl;

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned WINDOW    = 4;
    localparam int unsigned RESP_BITS = 2;
    localparam int          EXP_LAT   = RESP_BITS * (WINDOW + 4) + 1;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic [RESP_BITS-1:0] challenge;
    logic [CNT_W-1:0]     count_a;
    logic [CNT_W-1:0]     count_b;
    logic                 ctr_clear;
    logic                 ctr_enable;
    logic [3:0]           sel_a;
    logic [3:0]           sel_b;
    logic                 busy;
    logic                 done;
    logic [RESP_BITS-1:0] response;
    logic                 response_valid;
    logic                 tie;
    logic                 overflow;

    logic [CNT_W-1:0] ca [0:1];
    logic [CNT_W-1:0] cb [0:1];

    int n_vec;
    int n_err;

    puf_response_ctrl #(
        .CNT_W     (CNT_W),
        .WINDOW    (WINDOW),
        .RESP_BITS (RESP_BITS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .challenge      (challenge),
        .count_a        (count_a),
        .count_b        (count_b),
        .ctr_clear      (ctr_clear),
        .ctr_enable     (ctr_enable),
        .sel_a          (sel_a),
        .sel_b          (sel_b),
        .busy           (busy),
        .done           (done),
        .response       (response),
        .response_valid (response_valid),
        .tie            (tie),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pair i lives on RO indices 2i / 2i+1, so bit 1 of the select is the pair
    assign count_a = ca[sel_a[1]];
    assign count_b = cb[sel_b[1]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full run; optionally pulses a conflicting start during the first MEASURE
    task automatic run(input string tag, input logic [RESP_BITS-1:0] chal, input bit inject,
                       input logic [RESP_BITS-1:0] exp_resp, input logic exp_tie,
                       input logic exp_ovf);
        int lat;
        int both_hi;
        lat     = 0;
        both_hi = 0;
        @(negedge clk);
        challenge = chal;
        start     = 1'b1;
        @(posedge clk);
        #1;
        lat       = 1;
        start     = 1'b0;
        check({tag, " clear_first"}, 32'({ctr_clear, ctr_enable, busy}), 32'b101);
        check({tag, " flags_cleared"}, 32'({response_valid, tie, overflow}), 32'b000);
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (ctr_clear && ctr_enable) both_hi++;
            if (inject && lat == 3) begin
                start     = 1'b1;
                challenge = ~chal;
            end else begin
                start = 1'b0;
            end
            if (lat == 9) begin
                check({tag, " mid_resp"}, 32'(response), 32'(exp_resp & 2'b01));
                check({tag, " mid_sel"}, 32'({sel_a, sel_b}), 32'h23);
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(EXP_LAT));
        check({tag, " clr_en_excl"}, 32'(both_hi), 32'd0);
        check({tag, " response"}, 32'(response), 32'(exp_resp));
        check({tag, " valid_tie_ovf"}, 32'({response_valid, tie, overflow}),
              32'({1'b1, exp_tie, exp_ovf}));
        @(posedge clk);
        #1;
        check({tag, " after_done"}, 32'({done, busy, response_valid, ctr_clear, ctr_enable}),
              32'b00100);
    endtask

    initial begin
        int n;
        int dones;
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        start     = 1'b0;
        challenge = '0;
        ca[0] = 16'd10; cb[0] = 16'd7;
        ca[1] = 16'd3;  cb[1] = 16'd9;

        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 32'({busy, done, response, response_valid, tie, overflow, ctr_enable}),
              32'd0);
        check("reset_sel", 32'({sel_a, sel_b}), 32'd0);
        check("reset_clear", 32'(ctr_clear), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_clear", 32'({ctr_clear, busy}), 32'd0);

        // Basic run and challenge swap
        run("basic", 2'b00, 1'b0, 2'b01, 1'b0, 1'b0);
        run("swap", 2'b11, 1'b0, 2'b10, 1'b0, 1'b0);

        // Tie on pair 0 with challenge bit 1
        ca[0] = 16'd5; cb[0] = 16'd5;
        run("tie", 2'b01, 1'b0, 2'b01, 1'b1, 1'b0);

        // All-ones count, then a clean run must clear the sticky flag
        ca[0] = 16'hFFFF; cb[0] = 16'd1;
        run("ovf", 2'b00, 1'b0, 2'b01, 1'b0, 1'b1);
        ca[0] = 16'd10; cb[0] = 16'd7;
        run("ovf_clr", 2'b00, 1'b0, 2'b01, 1'b0, 1'b0);

        // Start while busy must not restart or re-capture the challenge
        run("ignored", 2'b00, 1'b1, 2'b01, 1'b0, 1'b0);

        // Reset during the second MEASURE
        @(negedge clk);
        challenge = 2'b00;
        start     = 1'b1;
        n         = 0;
        repeat (11) begin
            @(posedge clk);
            #1;
            n++;
            start = 1'b0;
        end
        check("mid_state", 32'({busy, ctr_enable, sel_a}), 32'({1'b1, 1'b1, 4'd2}));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reset", 32'({busy, done, response, ctr_enable, ctr_clear}), 32'b000001);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("no_done_after_reset", 32'(dones), 32'd0);
        run("after_reset", 2'b00, 1'b0, 2'b01, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
